// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU byte-bus target: RAM, UART TX FIFO / RX holding byte, cycle counter, stop flag
// Optional CYCLE_SNAPSHOT_EN: coherent 4-byte counter reads through a snapshot taken at 0x30004.
module cpu_bus_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow,
    output logic        program_done
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    ram_q [2**ADDR_WIDTH];
    logic [7:0]    ram_rd_q;
    logic [7:0]    tx_mem_q [TX_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, done_q, rx_full_q, rx_full_d, rd_ram_q;
    logic [7:0]    rx_q, io_rd_q, io_rdata;
    logic [31:0]   cyc_q;

    logic ram_sel, io_sel, uart_sel, cyc_sel, acc_rd, acc_wr;
    logic tx_push, tx_pop, tx_full, rx_load, rx_take;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic unused_addr;

    assign unused_addr = ^mem_a[31:18];
    assign ram_sel     = ~mem_a[17];
    assign io_sel      = &mem_a[17:16];
    assign uart_sel    = io_sel & (mem_a[2:0] == 3'd0);
    assign cyc_sel     = io_sel & mem_a[2];
    assign ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign acc_rd      = rdy_in & ~mem_wr;
    assign acc_wr      = rdy_in & mem_wr;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_full  = (cnt_q == CW'(TX_DEPTH));
    assign tx_push  = acc_wr & uart_sel & (mem_dout != 8'd0) & (~tx_full | tx_pop);
    assign tx_valid = (cnt_q != '0);
    assign tx_data  = tx_mem_q[rptr_q];
    assign io_buffer_full = (cnt_q >= CW'(TX_DEPTH - FULL_MARGIN));

    assign rx_ready  = ~rx_full_q;
    assign rx_load   = rx_valid & ~rx_full_q;
    assign rx_take   = acc_rd & uart_sel;
    assign rx_full_d = rx_load | (rx_full_q & ~rx_take);

    assign mem_din      = rd_ram_q ? ram_rd_q : io_rd_q;
    assign tx_overflow  = ovf_q;
    assign program_done = done_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef CYCLE_SNAPSHOT_EN
    logic [31:8] snap_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            snap_q <= '0;
        else if (acc_rd & io_sel & (mem_a[2:0] == 3'd4))
            snap_q <= cyc_q[31:8];
    end

    always_comb begin
        io_rdata = 8'd0;
        if (uart_sel)
            io_rdata = rx_full_q ? rx_q : 8'd0;
        else if (cyc_sel) begin
            case (mem_a[1:0])
                2'd0:    io_rdata = cyc_q[7:0];
                2'd1:    io_rdata = snap_q[15:8];
                2'd2:    io_rdata = snap_q[23:16];
                default: io_rdata = snap_q[31:24];
            endcase
        end
    end
`else
    always_comb begin
        io_rdata = 8'd0;
        if (uart_sel)
            io_rdata = rx_full_q ? rx_q : 8'd0;
        else if (cyc_sel) begin
            case (mem_a[1:0])
                2'd0:    io_rdata = cyc_q[7:0];
                2'd1:    io_rdata = cyc_q[15:8];
                2'd2:    io_rdata = cyc_q[23:16];
                default: io_rdata = cyc_q[31:24];
            endcase
        end
    end
`endif

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (acc_wr & ram_sel)
            ram_q[ram_idx] <= mem_dout;
        if (acc_rd & ram_sel)
            ram_rd_q <= ram_q[ram_idx];
        if (tx_push)
            tx_mem_q[wptr_q] <= mem_dout;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            rx_full_q <= 1'b0;
            rx_q      <= 8'd0;
            rd_ram_q  <= 1'b0;
            io_rd_q   <= 8'd0;
            cyc_q     <= 32'd0;
        end else begin
            if (tx_push)
                wptr_q <= wptr_q + PW'(1);
            if (tx_pop)
                rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
            if (acc_wr & uart_sel & (mem_dout != 8'd0) & tx_full & ~tx_pop)
                ovf_q <= 1'b1;
            if (acc_wr & io_sel & (mem_a[2:0] == 3'd4))
                done_q <= 1'b1;
            rx_full_q <= rx_full_d;
            if (rx_load)
                rx_q <= rx_data;
            if (rdy_in) begin
                rd_ram_q <= ~mem_wr & ram_sel;
                io_rd_q  <= mem_wr ? 8'd0 : io_rdata;
            end
            if (rdy_in & ~done_q)
                cyc_q <= cyc_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - directed table, corner sequences and random run against a queue-based model
module tb_cpu_bus_responder;
    localparam int TX_DEPTH    = 16;
    localparam int FULL_MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, rx_data;
    logic [7:0]  mem_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, tx_overflow, program_done;

    cpu_bus_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_overflow(tx_overflow), .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mram [int];
    logic [7:0]  mq [$];
    bit          m_rx_full, m_done, m_ovf, m_din_known;
    logic [7:0]  m_rx, m_din;
    logic [31:0] m_cnt, m_snap;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rx_full = 0; m_rx = 0; m_cnt = 0; m_snap = 0;
        m_done = 0; m_ovf = 0; m_din = 0; m_din_known = 1;
    endtask

    // Applies the bus rules to the inputs present at the clock edge.
    task automatic model_step();
        bit pop, load, done_pre, push;
        int rgn, off, idx;
        pop = (mq.size() > 0) && tx_ready;
        load = rx_valid && !m_rx_full;
        done_pre = m_done;
        push = 0;
        rgn = int'(mem_a[17:16]);
        off = int'(mem_a[2:0]);
        idx = int'(mem_a[16:0]);
        if (rdy_in) begin
            m_din = 0;
            m_din_known = 1;
            if (mem_wr) begin
                if (rgn < 2) mram[idx] = mem_dout;
                else if (rgn == 3 && off == 0 && mem_dout != 0) begin
                    if (mq.size() < TX_DEPTH || pop) push = 1;
                    else m_ovf = 1;
                end else if (rgn == 3 && off == 4) m_done = 1;
            end else begin
                if (rgn < 2) begin
                    if (mram.exists(idx)) m_din = mram[idx];
                    else m_din_known = 0;
                end else if (rgn == 3 && off == 0) begin
                    if (m_rx_full) m_din = m_rx;
                    m_rx_full = 0;
                end else if (rgn == 3 && off >= 4) begin
`ifdef CYCLE_SNAPSHOT_EN
                    if (off == 4) begin
                        m_snap = m_cnt;
                        m_din = 8'(m_cnt);
                    end else m_din = 8'(m_snap / (32'd1 << (8 * (off - 4))));
`else
                    m_din = 8'(m_cnt / (32'd1 << (8 * (off - 4))));
`endif
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(mem_dout);
        if (load) begin
            m_rx = rx_data;
            m_rx_full = 1;
        end
        if (rdy_in && !done_pre) m_cnt = m_cnt + 1;
    endtask

    task automatic check_outputs();
        if (m_din_known) chk("mem_din", mem_din, m_din);
        chk("tx_valid", tx_valid, mq.size() > 0);
        if (mq.size() > 0) chk("tx_data", tx_data, mq[0]);
        chk("io_buffer_full", io_buffer_full, mq.size() >= TX_DEPTH - FULL_MARGIN);
        chk("rx_ready", rx_ready, !m_rx_full);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("program_done", program_done, m_done);
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic bus(input bit wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in = 1; mem_wr = wr; mem_a = a; mem_dout = d;
        cycle();
    endtask

    task automatic idle();
        rdy_in = 1; mem_wr = 0; mem_a = 32'h0002_0000; mem_dout = 0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_in = 0;
        #1;
        chk({tag, " mem_din"}, mem_din, 8'h00);
        chk({tag, " tx_valid"}, tx_valid, 1'b0);
        chk({tag, " io_buffer_full"}, io_buffer_full, 1'b0);
        chk({tag, " rx_ready"}, rx_ready, 1'b1);
        chk({tag, " tx_overflow"}, tx_overflow, 1'b0);
        chk({tag, " program_done"}, program_done, 1'b0);
        model_reset();
        #2 rst_in = 1;
    endtask

    initial begin
        logic [31:0] word, exp_word;
        logic [7:0]  frozen;
        rst_in = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
        idle();
        model_reset();
        #12;
        chk("reset mem_din", mem_din, 8'h00);
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset rx_ready", rx_ready, 1'b1);
        chk("reset program_done", program_done, 1'b0);
        rst_in = 1;

        vecs[0] = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 32'h0002_0000, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 32'h0001_FFFF, 8'h5A, 8'h00};
        vecs[4] = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 32'hFFFC_0010, 8'h00, 8'hA5};
        vecs[6] = '{1'b1, 32'h0002_0010, 8'h77, 8'h00};
        vecs[7] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[8] = '{1'b0, 32'h0003_0001, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 32'h0003_0000, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].wr, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d mem_din", i), mem_din, vecs[i].exp);
        end

        // TX fill to overflow, then ordered drain
        for (int i = 1; i <= 14; i++) begin
            bus(1, 32'h0003_0000, 8'(i));
            if (i == 13) chk("ibf after 13", io_buffer_full, 1'b0);
        end
        chk("ibf after 14", io_buffer_full, 1'b1);
        bus(1, 32'h0003_0000, 8'h00);
        bus(1, 32'h0003_0000, 8'd15);
        bus(1, 32'h0003_0000, 8'd16);
        chk("no overflow at 16", tx_overflow, 1'b0);
        bus(1, 32'h0003_0000, 8'd17);
        chk("overflow at 17", tx_overflow, 1'b1);
        idle();
        tx_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain %0d tx_data", i), tx_data, 8'(i));
            chk($sformatf("drain %0d tx_valid", i), tx_valid, 1'b1);
            cycle();
        end
        tx_ready = 0;
        chk("drained tx_valid", tx_valid, 1'b0);

        // RX holding register
        rx_valid = 1; rx_data = 8'h3C;
        cycle();
        rx_valid = 0;
        chk("rx held rx_ready", rx_ready, 1'b0);
        bus(0, 32'h0003_0000, 8'h00);
        chk("rx read data", mem_din, 8'h3C);
        chk("rx read rx_ready", rx_ready, 1'b1);
        bus(0, 32'h0003_0000, 8'h00);
        chk("rx empty read", mem_din, 8'h00);

        // Counter after reset
        async_reset_check("reset1");
        idle();
        repeat (32'h1FF) cycle();
        word = 0;
        for (int b = 0; b < 4; b++) begin
            bus(0, 32'h0003_0004 + 32'(b), 8'h00);
            word[8*b +: 8] = mem_din;
        end
`ifdef CYCLE_SNAPSHOT_EN
        exp_word = 32'h0000_01FF;
`else
        exp_word = 32'h0000_02FF;
`endif
        chk("counter 4-byte read", word, exp_word);
        rdy_in = 0; mem_a = 32'h0003_0000; mem_wr = 1; mem_dout = 8'h99;
        repeat (10) cycle();
        bus(0, 32'h0003_0004, 8'h00);
        chk("counter after rdy low", mem_din, 8'h03);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int kind;
            logic [31:0] idx;
            rdy_in = ($urandom_range(0, 7) != 0);
            mem_wr = $urandom_range(0, 1) == 1;
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                idx = ($urandom_range(0, 1) == 1 ? 32'h10 : 32'h1FFF8) + 32'($urandom_range(0, 7));
                mem_a = ($urandom() & 32'hFFFC_0000) | idx;
            end else if (kind == 4) mem_a = 32'h0002_0000 | ($urandom() & 32'hFFFF);
            else if (kind <= 7) mem_a = 32'h0003_0000;
            else begin
                mem_a = 32'h0003_0000 | 32'($urandom_range(0, 7));
                if (mem_wr && mem_a[2:0] == 3'd4) mem_a[2:0] = 3'd5;
            end
            mem_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data = 8'($urandom());
            cycle();
        end

        // program_done freezes the counter; TX pushes still accepted
        tx_ready = 0; rx_valid = 0;
        idle();
        repeat (20) cycle();
        bus(1, 32'h0003_0004, 8'h55);
        chk("program_done set", program_done, 1'b1);
        frozen = 8'(m_cnt);
        bus(0, 32'h0003_0004, 8'h00);
        chk("frozen read 1", mem_din, frozen);
        idle();
        repeat (20) cycle();
        bus(0, 32'h0003_0004, 8'h00);
        chk("frozen read 2", mem_din, frozen);
        for (int i = 0; i < 17; i++) bus(1, 32'h0003_0000, 8'h42);
        chk("push after done tx_valid", tx_valid, 1'b1);
        chk("overflow before drain", tx_overflow, 1'b1);

        // Async reset mid-drain with 5 entries
        idle();
        tx_ready = 1;
        repeat (20) cycle();
        tx_ready = 0;
        for (int i = 1; i <= 5; i++) bus(1, 32'h0003_0000, 8'(i));
        idle();
        tx_ready = 1;
        chk("five queued tx_valid", tx_valid, 1'b1);
        async_reset_check("reset2");
        tx_ready = 0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
